// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types for the unified-memory fill arbiter: FSM states, grant sides,
// block geometry and a saturating counter helper.
// Imported by the arbiter top; the sequencer is purely parameter driven.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ISSUE,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

  // Bytes per cache block for the default 8 x 16-bit word geometry.
  localparam int BLOCK_BYTES = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Bundle of cache-side request/fill signals and memory-side request/return
// signals around the fill arbiter. master = arbiter view, slave = caches+memory.
// Perf counter outputs exist only when ARB_PERF_CNT_EN is defined.
interface cache_fill_arbiter_if #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);

  logic              ic_miss;
  logic [ADDR_W-1:0] ic_addr;
  logic              dc_miss;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_wr;
  logic [15:0]       dc_wdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  logic [15:0]       fill_data;
  logic [IDX_W-1:0]  fill_idx;
  logic              ic_fill_we;
  logic              dc_fill_we;
  logic              ic_done;
  logic              dc_done;
  logic              ic_busy;
  logic              dc_busy;

`ifdef ARB_PERF_CNT_EN
  logic [15:0]       ic_fill_cnt;
  logic [15:0]       dc_fill_cnt;
  logic [15:0]       wait_cyc_cnt;
`endif

  modport master (
    input  ic_miss, ic_addr, dc_miss, dc_addr, dc_wr, dc_wdata,
    input  mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_data, fill_idx, ic_fill_we, dc_fill_we,
    output ic_done, dc_done, ic_busy, dc_busy
`ifdef ARB_PERF_CNT_EN
    , output ic_fill_cnt, dc_fill_cnt, wait_cyc_cnt
`endif
  );

  modport slave (
    output ic_miss, ic_addr, dc_miss, dc_addr, dc_wr, dc_wdata,
    output mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_data, fill_idx, ic_fill_we, dc_fill_we,
    input  ic_done, dc_done, ic_busy, dc_busy
`ifdef ARB_PERF_CNT_EN
    , input ic_fill_cnt, dc_fill_cnt, wait_cyc_cnt
`endif
  );

endinterface

// File: rtl/cache_fill_arbiter_fill_sequencer.sv
// Block fill bookkeeping: read-issue counter, return counter, block-aligned address.
// Latency: address is combinational from the issue counter; counters step on posedge.
// Backpressure: none; issue_en/rx_en are driven by the arbiter FSM each cycle.
module fill_sequencer #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           issue_en,
  input  logic                           rx_en,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic [ADDR_W-1:0]              rd_addr,
  output logic [$clog2(BLOCK_WORDS)-1:0] rx_idx,
  output logic                           issue_last,
  output logic                           rx_last
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  // One extra bit so the issue counter can step past the last word without wrapping.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic [ADDR_W-1:0] base;

  // Clear on a new grant, then count issued reads and accepted returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else if (clear) begin
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else begin
      if (issue_en) issue_cnt <= issue_cnt + CNT_W'(1);
      if (rx_en)    rx_cnt    <= rx_cnt + CNT_W'(1);
    end
  end

  assign base       = req_addr & ~BLK_MASK;
  assign rd_addr    = base + (ADDR_W'(issue_cnt) << 1);
  assign rx_idx     = rx_cnt[IDX_W-1:0];
  assign issue_last = (issue_cnt == LAST_CNT);
  assign rx_last    = (rx_cnt == LAST_CNT);

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one memory between I-fills, D-fills and D write-through stores.
// Latency: grant registered 1 cycle after request; store done in WRITE cycle; fill done with last return.
// Backpressure: requesters stall on ic_busy/dc_busy; optional perf counters under ARB_PERF_CNT_EN.
module cache_fill_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_fill_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  // With MEM_LATENCY >= BLOCK_WORDS the first return cannot precede the last
  // issue, so a return seen during ISSUE can only be a stray and is dropped.
  localparam bit EARLY_RET = (MEM_LATENCY < BLOCK_WORDS);

  arb_state_t        st_q, st_d;
  grant_t            gnt_q, gnt_d;
  grant_t            last_q, last_d;
  grant_t            pick;
  logic              take;
  logic              accept;
  logic              rx_done;
  logic              in_service;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  rx_idx;
  logic              issue_last;
  logic              rx_last;

  fill_sequencer #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (take),
    .issue_en   (st_q == ISSUE),
    .rx_en      (accept),
    .req_addr   (addr_q),
    .rd_addr    (rd_addr),
    .rx_idx     (rx_idx),
    .issue_last (issue_last),
    .rx_last    (rx_last)
  );

  // Pick a side: a lone requester wins, contention goes to the side not served last.
  always_comb begin
    pick = (last_q == GNT_I) ? GNT_D : GNT_I;
    if (bus.dc_miss && !bus.ic_miss) begin
      pick = GNT_D;
    end else if (bus.ic_miss && !bus.dc_miss) begin
      pick = GNT_I;
    end
  end

  // Next state and grant capture; requests are only looked at in IDLE.
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    last_d = last_q;
    take   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.ic_miss || bus.dc_miss) begin
          take   = 1'b1;
          gnt_d  = pick;
          last_d = pick;
          st_d   = (pick == GNT_D && bus.dc_wr) ? WRITE : ISSUE;
        end
      end
      WRITE: st_d = IDLE;
      ISSUE: begin
        if (rx_done) begin
          st_d = IDLE;
        end else if (issue_last) begin
          st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_done) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      gnt_q  <= GNT_I;
      last_q <= GNT_I;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  // Hold the granted address and store data for the whole service so a
  // requester changing its inputs mid-service has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      addr_q  <= (pick == GNT_D) ? bus.dc_addr : bus.ic_addr;
      wdata_q <= bus.dc_wdata;
    end
  end

  // Memory request drive: one store beat in WRITE, one read per cycle in ISSUE.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (st_q)
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      ISSUE: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  // Returns count only while a fill is in flight; IDLE/WRITE returns are ignored.
  assign accept     = bus.mem_valid && ((st_q == DRAIN) || (EARLY_RET && st_q == ISSUE));
  assign rx_done    = accept && rx_last;
  assign in_service = (st_q != IDLE);

  assign bus.fill_data  = accept ? bus.mem_rdata : 16'h0000;
  assign bus.fill_idx   = accept ? rx_idx : '0;
  assign bus.ic_fill_we = accept && (gnt_q == GNT_I);
  assign bus.dc_fill_we = accept && (gnt_q == GNT_D);
  assign bus.ic_done    = rx_done && (gnt_q == GNT_I);
  assign bus.dc_done    = (st_q == WRITE) || (rx_done && (gnt_q == GNT_D));
  assign bus.ic_busy    = bus.ic_miss || ((gnt_q == GNT_I) && in_service);
  assign bus.dc_busy    = bus.dc_miss || ((gnt_q == GNT_D) && in_service);

`ifdef ARB_PERF_CNT_EN
  logic [15:0] ic_fill_cnt_q;
  logic [15:0] dc_fill_cnt_q;
  logic [15:0] wait_cyc_cnt_q;
  logic        ic_wait;
  logic        dc_wait;

  assign ic_wait = bus.ic_miss && !((gnt_q == GNT_I) && in_service);
  assign dc_wait = bus.dc_miss && !((gnt_q == GNT_D) && in_service);

  // Completed block fills per side and cycles with an unserved request, all saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_fill_cnt_q  <= '0;
      dc_fill_cnt_q  <= '0;
      wait_cyc_cnt_q <= '0;
    end else begin
      if (rx_done && gnt_q == GNT_I) ic_fill_cnt_q <= sat_inc16(ic_fill_cnt_q);
      if (rx_done && gnt_q == GNT_D) dc_fill_cnt_q <= sat_inc16(dc_fill_cnt_q);
      if (ic_wait || dc_wait)        wait_cyc_cnt_q <= sat_inc16(wait_cyc_cnt_q);
    end
  end

  assign bus.ic_fill_cnt  = ic_fill_cnt_q;
  assign bus.dc_fill_cnt  = dc_fill_cnt_q;
  assign bus.wait_cyc_cnt = wait_cyc_cnt_q;
`endif

endmodule
